// File: rtl/pc_seq_unit_if.sv
// rtl/pc_seq_unit_if.sv - control and status bundle between fetch control and the PC unit
interface pc_seq_unit_if #(
    parameter int WIDTH = 32
);
    logic             stall;
    logic             br_taken;
    logic [WIDTH-1:0] br_offset;
    logic             jump;
    logic [WIDTH-1:0] jump_target;
    logic             call;
    logic             ret;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus;
    logic             misalign;
    logic             ras_empty;
    logic             ras_full;

    modport master (
        output stall, br_taken, br_offset, jump, jump_target, call, ret,
        input  pc, pc_plus, misalign, ras_empty, ras_full
    );

    modport slave (
        input  stall, br_taken, br_offset, jump, jump_target, call, ret,
        output pc, pc_plus, misalign, ras_empty, ras_full
    );
endinterface

// File: rtl/pc_seq_unit.sv
// rtl/pc_seq_unit.sv - registered program counter with branch, jump, misalign trap and circular return-address stack
module pc_seq_unit #(
    parameter int               WIDTH        = 32,
    parameter int unsigned      STEP         = 4,
    parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [WIDTH-1:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int               RAS_DEPTH    = 4
) (
    input  logic          clk,
    input  logic          rst,
    pc_seq_unit_if.slave  bus
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] r_pc;
    logic             r_misalign;
    logic [WIDTH-1:0] r_ras [RAS_DEPTH];
    logic [PW-1:0]    r_ptr;
    logic [CW-1:0]    r_cnt;

    logic [WIDTH-1:0] w_pc_plus;
    logic [PW-1:0]    w_top_idx;
    logic [WIDTH-1:0] w_ras_top;
    logic             w_empty;
    logic             w_full;
    logic [WIDTH-1:0] w_cand;
    logic             w_redirect;
    logic             w_trap;
    logic             w_push;
    logic             w_pop;
    logic             w_swap;

    assign w_pc_plus = r_pc + WIDTH'(STEP);
    assign w_top_idx = r_ptr - PW'(1);
    assign w_ras_top = r_ras[w_top_idx];
    assign w_empty   = (r_cnt == '0);
    assign w_full    = (r_cnt == CW'(RAS_DEPTH));

    always_comb begin
        w_cand     = w_pc_plus;
        w_redirect = 1'b0;
        if (bus.ret) begin
            w_cand     = w_empty ? bus.jump_target : w_ras_top;
            w_redirect = 1'b1;
        end else if (bus.jump) begin
            w_cand     = bus.jump_target;
            w_redirect = 1'b1;
        end else if (bus.br_taken) begin
            w_cand     = r_pc + bus.br_offset;
            w_redirect = 1'b1;
        end
    end

    // Only redirects can trap; sequential fetch stays aligned by construction.
    assign w_trap = w_redirect && (w_cand[1:0] != 2'b00);
    assign w_push = bus.call && bus.jump && !bus.ret;
    assign w_pop  = bus.ret && !bus.call && !w_empty;
    assign w_swap = bus.call && bus.ret;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc       <= RESET_VECTOR;
            r_misalign <= 1'b0;
            r_ptr      <= '0;
            r_cnt      <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) r_ras[i] <= '0;
        end else if (bus.stall) begin
            r_misalign <= 1'b0;
        end else begin
            r_pc       <= w_trap ? TRAP_VECTOR : w_cand;
            r_misalign <= w_trap;
            if (w_push) begin
                r_ras[r_ptr] <= w_pc_plus;
                r_ptr        <= r_ptr + PW'(1);
                if (!w_full) r_cnt <= r_cnt + CW'(1);
            end else if (w_pop) begin
                r_ptr <= w_top_idx;
                r_cnt <= r_cnt - CW'(1);
            end else if (w_swap) begin
                // jalr ra,ra: replace the top, or seed a single entry when empty
                if (w_empty) begin
                    r_ras[r_ptr] <= w_pc_plus;
                    r_ptr        <= r_ptr + PW'(1);
                    r_cnt        <= CW'(1);
                end else begin
                    r_ras[w_top_idx] <= w_pc_plus;
                end
            end
        end
    end

    assign bus.pc        = r_pc;
    assign bus.pc_plus   = w_pc_plus;
    assign bus.misalign  = r_misalign;
    assign bus.ras_empty = w_empty;
    assign bus.ras_full  = w_full;
endmodule

// File: doc/pc_seq_unit.md
# pc_seq_unit

Parametrised program-counter unit for the single-cycle core. It replaces the bare PC-plus-constant adder with a registered PC that supports sequential fetch, stall, PC-relative branch, absolute jump, call/return through a return-address stack (RAS), and misaligned-target trapping. It sits at the front of fetch: `pc` drives instruction memory, and `pc_plus` feeds the writeback mux for link registers.

## Interface
- `WIDTH`, 32: PC and address width in bits.
- `STEP`, 4: sequential increment in bytes.
- `RESET_VECTOR`, 32'h0000_0000: PC value after reset.
- `TRAP_VECTOR`, 32'h0000_0100: PC loaded on a misaligned redirect.
- `RAS_DEPTH`, 4: number of RAS entries; must be a power of two and at least 2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `stall`  in  1  hold PC and RAS unchanged.
- `br_taken`  in  1  take the PC-relative branch.
- `br_offset`  in  WIDTH  two's-complement byte offset added to `pc`.
- `jump`  in  1  absolute redirect to `jump_target`.
- `jump_target`  in  WIDTH  absolute target; also the fallback target for a return when the RAS is empty.
- `call`  in  1  push `pc_plus` onto the RAS; only valid together with `jump`.
- `ret`  in  1  redirect to the RAS top and pop.
- `pc`  out  WIDTH  current PC (registered).
- `pc_plus`  out  WIDTH  `pc + STEP`, combinational.
- `misalign`  out  1  registered; high for one cycle after a trapped redirect.
- `ras_empty`  out  1  RAS count is 0.
- `ras_full`  out  1  RAS count equals `RAS_DEPTH`.

## Operation
- **Reset** (`rst`=0 at an edge):
  - `pc`=RESET_VECTOR, `misalign`=0.
  - RAS count=0, RAS pointer=0, all entries=0.
  - Hence `ras_empty`=1, `ras_full`=0.
- **Candidate next PC**, highest priority first:
  1. `stall`: `pc` holds, RAS holds, `misalign`<=0, all other controls are ignored.
  2. `ret`: next PC is the RAS top if the RAS is non-empty, otherwise `jump_target`.
  3. `jump`: next PC is `jump_target`.
  4. `br_taken`: next PC is `pc + br_offset`.
  5. Otherwise: next PC is `pc_plus`.
- **Arithmetic:** all additions are modulo 2^WIDTH. Wrap-around from all-ones to 0 is silent and is not an error.
- **Misalignment:**
  - A redirect (cases 2-4) whose candidate has bits [1:0] ≠ 0 loads TRAP_VECTOR instead of the candidate and sets `misalign`<=1.
  - Sequential fetch never traps.
  - `misalign` clears on the next non-trapping edge.
- **RAS is a circular stack.** Rules when not stalled:
  - **Push** (`call` & `jump`, no `ret`): write `pc_plus` at the pointer, advance the pointer, count = min(count+1, RAS_DEPTH). When full, the oldest entry is overwritten silently.
  - **Pop** (`ret`, no `call`, count>0): retreat the pointer, count−1.
  - **Pop on empty:** no state change and no error; the target falls back to `jump_target`.
  - **`call` and `ret` together** (jalr ra,ra style): the next PC follows the `ret` rule. The top entry, or a new entry if the RAS is empty, is replaced with `pc_plus`. Count is unchanged when non-empty and becomes 1 when empty.
  - **`call` without `jump`:** ignored.
- A trapped redirect still performs its RAS push/pop. Software recovers through the trap handler.

## Timing
- The selected next PC appears on `pc` one clock after the controls are sampled. Redirect latency is 1 cycle; there is no bubble inside this block.
- `pc_plus`, `ras_empty` and `ras_full` are combinational from registered state.
- Reset has priority over all other inputs on the same edge.
- Reset asserted mid-sequence discards RAS contents on that edge.
- Inputs must be stable around the rising edge of `clk`. The block has no internal combinational path from inputs to outputs.

## Test plan
- **Reset then free-run:** hold `rst`=0 for 2 cycles, release, no controls. `pc` reads 0x0, 0x4, 0x8, 0xC on successive cycles; `misalign`=0.
- **Branch and stall:**
  - `pc`=0x10 with `br_taken`=1, `br_offset`=0xFFFF_FFF8 → `pc`=0x08.
  - Then `stall`=1 for 3 cycles with `jump`=1 → `pc` stays 0x08.
- **Call/return:**
  - At `pc`=0x20, `call`+`jump`, `jump_target`=0x100 → `pc`=0x100, RAS top=0x24.
  - Later `ret` → `pc`=0x24, `ras_empty`=1.
- **RAS overflow and underflow (RAS_DEPTH=4):**
  - 5 calls from 0x0, 0x10, 0x20, 0x30, 0x40, each targeting 0x1000 → `ras_full`=1.
  - 4 rets return 0x44, 0x34, 0x24, 0x14.
  - A 5th ret with `jump_target`=0x200 → `pc`=0x200, RAS count stays 0.
- **Misaligned jump:** `jump_target`=0x102 → `pc`=TRAP_VECTOR (0x100) and `misalign`=1 for exactly one cycle, then `pc`=0x104.
- **Wrap:** force `pc`=0xFFFF_FFFC via `jump` → next sequential `pc`=0x0 with no flag. Also verify that a simultaneous `call`+`ret` with the RAS empty yields count 1 and top = `pc_plus`.
